// File: rtl/phy_tx_serial.sv
// Two-lane serial PHY transmitter: per-lane byte hold + MSB-first shifter on a shared
// bit counter, with a COMMA alignment burst after reset and COMMA fill on idle slots.
module phy_tx_serial #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned INIT_COMMAS = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  output logic       ready_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       ready_1,
  output logic       data_out0,
  output logic       data_out1,
  output logic       active
);

  localparam logic [3:0] INIT_CNT = 4'(INIT_COMMAS);

  typedef enum logic {ST_SYNC = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      comma_cnt_q, comma_cnt_d;
  logic            in_rst_q;
  logic [1:0][7:0] shift_q, shift_d;
  logic [1:0][7:0] hold_q, hold_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][7:0] din;
  logic [1:0]      vld, rdy;
  logic            boundary, sync_done, load_data;

  assign din       = {data_in_1, data_in_0};
  assign vld       = {valid_in_1, valid_in_0};
  assign boundary  = (cnt_q == 3'd7);
  assign sync_done = (comma_cnt_q == INIT_CNT);
  // The boundary that completes the burst already loads with ACTIVE rules.
  assign load_data = boundary && ((state_q == ST_ACTIVE) || sync_done);

  always_ff @(posedge clk_8f) begin
    if (!reset) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_SYNC && boundary && sync_done) state_d = ST_ACTIVE;
  end

  always_comb begin
    active = (state_q == ST_ACTIVE);
    rdy    = '0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = !in_rst_q && (!full_q[i] || load_data);
    end
    ready_0 = rdy[0];
    ready_1 = rdy[1];
  end

  always_comb begin
    cnt_d       = boundary ? 3'd0 : cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    if (state_q == ST_SYNC && boundary && !sync_done) comma_cnt_d = comma_cnt_q + 4'd1;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    for (int i = 0; i < 2; i++) begin
      shift_d[i] = {shift_q[i][6:0], 1'b0};
      if (boundary) begin
        if (load_data && full_q[i]) begin
          shift_d[i] = hold_q[i];
          full_d[i]  = 1'b0;
        end else begin
          shift_d[i] = COMMA;
        end
      end
      // A new accept overrides the drain above, so load and refill can share one edge.
      if (vld[i] && rdy[i]) begin
        hold_d[i] = din[i];
        full_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      cnt_q       <= 3'd7;
      comma_cnt_q <= 4'd0;
      in_rst_q    <= 1'b1;
      shift_q     <= '0;
      full_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      comma_cnt_q <= comma_cnt_d;
      in_rst_q    <= 1'b0;
      shift_q     <= shift_d;
      full_q      <= full_d;
    end
  end

  always_ff @(posedge clk_8f) begin
    hold_q <= hold_d;
  end

  assign data_out0 = shift_q[0][7];
  assign data_out1 = shift_q[1][7];

endmodule

// File: tb/tb_phy_tx_serial.sv
// Directed bench for phy_tx_serial: symbol-window capture of both lanes against
// hand-computed bytes, a per-window vector table, and hand sequences for corner cases.
module tb_phy_tx_serial;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic [7:0] data_in_0, data_in_1;
  logic       valid_in_0, valid_in_1;
  logic       ready_0, ready_1;
  logic       data_out0, data_out1;
  logic       active;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  typedef struct {
    string      name;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tbl[9];

  phy_tx_serial dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in_0 (data_in_0),
    .valid_in_0(valid_in_0),
    .ready_0   (ready_0),
    .data_in_1 (data_in_1),
    .valid_in_1(valid_in_1),
    .ready_1   (ready_1),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .active    (active)
  );

  always #5 clk_8f = ~clk_8f;

  function automatic vec_t mk(string n, logic v0, logic [7:0] d0, logic v1, logic [7:0] d1,
                              logic [7:0] e0, logic [7:0] e1);
    vec_t r;
    r.name = n; r.v0 = v0; r.d0 = d0; r.v1 = v1; r.d1 = d1; r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic check(string nm, logic [15:0] got, logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic refresh();
    valid_in_0 = (q0.size() != 0);
    data_in_0  = valid_in_0 ? q0[0] : 8'h00;
    valid_in_1 = (q1.size() != 0);
    data_in_1  = valid_in_1 ? q1[0] : 8'h00;
  endtask

  // One clock edge; an upstream byte leaves its queue when valid&&ready held before the edge.
  task automatic tick();
    logic f0, f1;
    f0 = valid_in_0 && ready_0;
    f1 = valid_in_1 && ready_1;
    @(posedge clk_8f);
    #1;
    if (f0) q0.delete(0);
    if (f1) q1.delete(0);
    refresh();
  endtask

  task automatic collect(output logic [7:0] b0, output logic [7:0] b1,
                         output logic [7:0] rdy, output logic act_first);
    b0 = '0; b1 = '0; rdy = '0; act_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      b0  = {b0[6:0], data_out0};
      b1  = {b1[6:0], data_out1};
      rdy = {rdy[6:0], ready_0};
      if (i == 0) act_first = active;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    refresh();
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] b0, b1, rdy;
    logic       af;

    reset = 1'b0;
    q0.delete();
    q1.delete();
    refresh();

    // Reset release with no traffic: COMMA burst, then ACTIVE.
    apply_reset();
    check("rst_do0", 16'(data_out0), 16'h0);
    check("rst_do1", 16'(data_out1), 16'h0);
    check("rst_ready", {14'h0, ready_1, ready_0}, 16'h0);
    check("rst_active", 16'(active), 16'h0);
    reset = 1'b1;
    #1;
    check("ready_before_e0", {14'h0, ready_1, ready_0}, 16'h0);
    collect(b0, b1, rdy, af);
    check("sync_w0", {b0, b1}, 16'hBCBC);
    check("sync_w0_ready", 16'(rdy), 16'h00FF);
    for (int w = 1; w < 4; w++) begin
      collect(b0, b1, rdy, af);
      check($sformatf("sync_w%0d", w), {b0, b1}, 16'hBCBC);
    end
    check("active_before_e32", 16'(active), 16'h0);
    collect(b0, b1, rdy, af);
    check("active_w4", {b0, b1}, 16'hBCBC);
    check("active_after_e32", 16'(af), 16'h1);

    // Streaming table: bytes pushed at each window start, output one window later.
    tbl[0] = mk("stream_01", 1'b1, 8'h01, 1'b1, 8'h01, 8'hBC, 8'hBC);
    tbl[1] = mk("stream_ff", 1'b1, 8'hFF, 1'b1, 8'hFF, 8'h01, 8'h01);
    tbl[2] = mk("stream_3c", 1'b1, 8'h3C, 1'b1, 8'h3C, 8'hFF, 8'hFF);
    tbl[3] = mk("l0_55_a",   1'b1, 8'h55, 1'b0, 8'h00, 8'h3C, 8'h3C);
    tbl[4] = mk("l0_55_b",   1'b1, 8'h55, 1'b0, 8'h00, 8'h55, 8'hBC);
    tbl[5] = mk("l1_c3",     1'b0, 8'h00, 1'b1, 8'hC3, 8'h55, 8'hBC);
    tbl[6] = mk("l0_comma",  1'b1, 8'hBC, 1'b0, 8'h00, 8'hBC, 8'hC3);
    tbl[7] = mk("idle_a",    1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 8'hBC);
    tbl[8] = mk("idle_b",    1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 8'hBC);
    for (int r = 0; r < 9; r++) begin
      if (tbl[r].v0) q0.push_back(tbl[r].d0);
      if (tbl[r].v1) q1.push_back(tbl[r].d1);
      refresh();
      collect(b0, b1, rdy, af);
      check(tbl[r].name, {b0, b1}, {tbl[r].e0, tbl[r].e1});
    end

    // Byte accepted during SYNC waits for the first ACTIVE boundary.
    apply_reset();
    reset = 1'b1;
    tick();
    tick();
    q0.push_back(8'hA5);
    refresh();
    tick();
    check("sync_hold_ready0", 16'(ready_0), 16'h0);
    check("sync_hold_ready1", 16'(ready_1), 16'h1);
    for (int i = 0; i < 5; i++) tick();
    collect(b0, b1, rdy, af);
    check("sync_hold_w1", {b0, b1}, 16'hBCBC);
    check("sync_hold_w1_ready", 16'(rdy), 16'h0000);
    collect(b0, b1, rdy, af);
    collect(b0, b1, rdy, af);
    check("sync_hold_w3_ready", 16'(rdy), 16'h0001);
    collect(b0, b1, rdy, af);
    check("sync_hold_w4", {b0, b1}, 16'hA5BC);
    check("sync_hold_w4_ready", 16'(rdy), 16'h00FF);
    check("sync_hold_active", 16'(af), 16'h1);

    // Reset mid-symbol with a held byte: output clears, byte discarded, burst repeats.
    apply_reset();
    reset = 1'b1;
    for (int w = 0; w < 4; w++) collect(b0, b1, rdy, af);
    tick();
    tick();
    tick();
    q0.push_back(8'h5A);
    refresh();
    tick();
    tick();
    check("pre_rst_ready0", 16'(ready_0), 16'h0);
    check("pre_rst_do0", 16'(data_out0), 16'h1);
    reset = 1'b0;
    q0.delete();
    refresh();
    tick();
    check("mid_rst_do", {14'h0, data_out1, data_out0}, 16'h0);
    check("mid_rst_ready", {14'h0, ready_1, ready_0}, 16'h0);
    reset = 1'b1;
    for (int w = 0; w < 4; w++) begin
      collect(b0, b1, rdy, af);
      check($sformatf("re_sync_w%0d", w), {b0, b1}, 16'hBCBC);
    end
    check("re_sync_active", 16'(active), 16'h0);
    collect(b0, b1, rdy, af);
    check("re_active_w4", {b0, b1}, 16'hBCBC);
    check("re_active_flag", 16'(af), 16'h1);

    // Hold full off-boundary: second byte waits for the boundary edge.
    q0.push_back(8'h11);
    q0.push_back(8'h22);
    refresh();
    collect(b0, b1, rdy, af);
    check("full_w0", {b0, b1}, 16'hBCBC);
    check("full_w0_ready", 16'(rdy), 16'h0001);
    collect(b0, b1, rdy, af);
    check("full_w1", {b0, b1}, 16'h11BC);
    check("full_w1_ready", 16'(rdy), 16'h0001);
    collect(b0, b1, rdy, af);
    check("full_w2", {b0, b1}, 16'h22BC);
    check("full_w2_ready", 16'(rdy), 16'h00FF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
